// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional ILLEGAL_TRAP_EN: unknown opcodes trap to HALT and raise a sticky illegal flag.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       is_branch,
    output logic       is_jump,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic [2:0] alu_ctl,
    output logic [3:0] state,
    output logic       fault
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam bit TO_EN = (MEM_TIMEOUT != 0);

    state_t        st, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    r_ctl;
    logic          is_r, is_addi, is_mem, is_beq, is_j;
    logic          waiting, to_hit;
    logic          ill_set;

    assign is_r    = (opcode == 6'b000000);
    assign is_addi = (opcode == 6'b001000);
    assign is_mem  = (opcode == 6'b100011) || (opcode == 6'b101011);
    assign is_beq  = (opcode == 6'b000100);
    assign is_j    = (opcode == 6'b000010);

    assign state = st;

    // A wait cycle is any memory-facing state still stalled on mem_ready.
    assign waiting = ((st == FETCH) || (st == MEM_RD) || (st == MEM_WR))
                   && !mem_ready;
    assign to_hit  = TO_EN && waiting && (cnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        r_ctl = ALU_ADD;
        unique case (funct)
            6'b100010: r_ctl = ALU_SUB;
            6'b100100: r_ctl = ALU_AND;
            6'b100101: r_ctl = ALU_OR;
            6'b101010: r_ctl = ALU_SLT;
            default:   r_ctl = ALU_ADD;
        endcase
    end

    always_comb begin
        nxt        = st;
        ill_set    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_ctl    = 3'b000;
        unique case (st)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end
            end
            DECODE: begin
                unique case (1'b1)
                    is_r:    nxt = EXEC_R;
                    is_addi: nxt = EXEC_I;
                    is_mem:  nxt = MEM_ADDR;
                    is_beq:  nxt = BRANCH;
                    is_j:    nxt = JUMP;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        nxt     = HALT;
                        ill_set = 1'b1;
`else
                        nxt     = FETCH;
`endif
                    end
                endcase
            end
            EXEC_R: begin
                reg_dst = 1'b1;
                alu_ctl = r_ctl;
                nxt     = WB_ALU;
            end
            EXEC_I: begin
                alu_src = 1'b1;
                alu_ctl = ALU_ADD;
                nxt     = WB_ALU;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = is_r;
                alu_src   = !is_r;
                alu_ctl   = is_r ? r_ctl : ALU_ADD;
                nxt       = FETCH;
            end
            MEM_ADDR: begin
                alu_src = 1'b1;
                alu_ctl = ALU_ADD;
                nxt     = (opcode == 6'b101011) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
                alu_ctl  = ALU_ADD;
                if (mem_ready) nxt = WB_MEM;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = ALU_ADD;
                if (mem_ready) nxt = FETCH;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = FETCH;
            end
            BRANCH: begin
                alu_ctl = ALU_SUB;
                if (zero) begin
                    is_branch = 1'b1;
                    pc_write  = 1'b1;
                end
                nxt = FETCH;
            end
            JUMP: begin
                is_jump  = 1'b1;
                pc_write = 1'b1;
                nxt      = FETCH;
            end
            default: nxt = HALT;
        endcase
        if (to_hit) nxt = HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= FETCH;
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            st <= nxt;
            if (nxt != st) cnt <= '0;
            else if (waiting) cnt <= cnt + 1'b1;
            if (to_hit) fault <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) illegal <= 1'b0;
        else if (ill_set) illegal <= 1'b1;
    end
`else
    logic unused_ill;
    assign unused_ill = ill_set;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control vectors.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_write, pc_write, is_branch, is_jump;
    logic       mem_read, mem_write, reg_write, reg_dst;
    logic       alu_src, mem_to_reg, fault;
    logic [2:0] alu_ctl;
    logic [3:0] state;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write),
        .is_branch(is_branch), .is_jump(is_jump),
        .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .alu_ctl(alu_ctl), .state(state), .fault(fault)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    logic [12:0] ctl;
    assign ctl = {ir_write, pc_write, is_branch, is_jump, mem_read,
                  mem_write, reg_write, reg_dst, alu_src, mem_to_reg,
                  alu_ctl};

    function automatic logic [12:0] v(
        input bit ir, input bit pc, input bit br, input bit jp,
        input bit mr, input bit mw, input bit rw, input bit rd,
        input bit as, input bit m2r, input logic [2:0] alu);
        return {ir, pc, br, jp, mr, mw, rw, rd, as, m2r, alu};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input int es,
                        input logic [12:0] ev);
        #1;
        check({tag, ".st"}, 32'(state), 32'(es));
        check({tag, ".ctl"}, 32'(ctl), 32'(ev));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst.st", 32'(state), 32'd0);
        check("rst.fault", 32'(fault), 32'd0);
    endtask

    task automatic fetch(input string tag);
        mem_ready = 1'b1;
        step({tag, ".fetch"}, 0, v(1,1,0,0,1,0,0,0,0,0,3'b000));
    endtask

    initial begin
        do_reset();

        // R-type sub
        opcode = 6'b000000; funct = 6'b100010;
        fetch("sub");
        step("sub.dec", 1, '0);
        step("sub.ex", 2, v(0,0,0,0,0,0,0,1,0,0,3'b110));
        step("sub.wb", 7, v(0,0,0,0,0,0,1,1,0,0,3'b110));

        // R-type slt and unknown funct (add)
        funct = 6'b101010;
        fetch("slt");
        step("slt.dec", 1, '0);
        step("slt.ex", 2, v(0,0,0,0,0,0,0,1,0,0,3'b111));
        step("slt.wb", 7, v(0,0,0,0,0,0,1,1,0,0,3'b111));
        funct = 6'b111000;
        fetch("rdf");
        step("rdf.dec", 1, '0);
        step("rdf.ex", 2, v(0,0,0,0,0,0,0,1,0,0,3'b010));
        step("rdf.wb", 7, v(0,0,0,0,0,0,1,1,0,0,3'b010));

        // addi
        opcode = 6'b001000; funct = 6'b100100;
        fetch("addi");
        step("addi.dec", 1, '0);
        step("addi.ex", 3, v(0,0,0,0,0,0,0,0,1,0,3'b010));
        step("addi.wb", 7, v(0,0,0,0,0,0,1,0,1,0,3'b010));

        // lw with 3 wait cycles in MEM_RD
        opcode = 6'b100011;
        fetch("lw");
        step("lw.dec", 1, '0);
        step("lw.addr", 4, v(0,0,0,0,0,0,0,0,1,0,3'b010));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("lw.wait", 5, v(0,0,0,0,1,0,0,0,1,0,3'b010));
        mem_ready = 1'b1;
        step("lw.rd", 5, v(0,0,0,0,1,0,0,0,1,0,3'b010));
        step("lw.wb", 8, v(0,0,0,0,0,0,1,0,0,1,3'b000));

        // sw: mem_write drops once back in FETCH
        opcode = 6'b101011;
        fetch("sw");
        step("sw.dec", 1, '0);
        step("sw.addr", 4, v(0,0,0,0,0,0,0,0,1,0,3'b010));
        step("sw.wr", 6, v(0,0,0,0,0,1,0,0,1,0,3'b010));
        #1;
        check("sw.mw_off", 32'(mem_write), 32'd0);

        // beq taken / not taken
        opcode = 6'b000100; zero = 1'b1;
        fetch("beq1");
        step("beq1.dec", 1, '0);
        step("beq1.br", 9, v(0,1,1,0,0,0,0,0,0,0,3'b110));
        zero = 1'b0;
        fetch("beq0");
        step("beq0.dec", 1, '0);
        step("beq0.br", 9, v(0,0,0,0,0,0,0,0,0,0,3'b110));

        // jump
        opcode = 6'b000010;
        fetch("j");
        step("j.dec", 1, '0);
        step("j.jmp", 10, v(0,1,0,1,0,0,0,0,0,0,3'b000));
        mem_ready = 1'b0;
        step("j.back", 0, v(0,0,0,0,1,0,0,0,0,0,3'b000));

        // reset in MEM_WR: write still drives, next state FETCH
        do_reset();
        opcode = 6'b101011;
        fetch("swr");
        step("swr.dec", 1, '0);
        mem_ready = 1'b0;
        step("swr.addr", 4, v(0,0,0,0,0,0,0,0,1,0,3'b010));
        reset = 1'b1;
        step("swr.rst", 6, v(0,0,0,0,0,1,0,0,1,0,3'b010));
        reset = 1'b0;
        check("swr.st", 32'(state), 32'd0);

        // FETCH timeout after 16 wait cycles
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            step("to.wait", 0, v(0,0,0,0,1,0,0,0,0,0,3'b000));
        #1;
        check("to.fault", 32'(fault), 32'd1);
        mem_ready = 1'b1;
        step("to.halt", 11, '0);
        step("to.hold", 11, '0);
        check("to.sticky", 32'(fault), 32'd1);
        do_reset();

        // unknown opcode
        opcode = 6'b111111;
        fetch("ill");
`ifdef ILLEGAL_TRAP_EN
        step("ill.dec", 1, '0);
        #1;
        check("ill.flag", 32'(illegal), 32'd1);
        step("ill.halt", 11, '0);
        do_reset();
        check("ill.clr", 32'(illegal), 32'd0);
`else
        step("ill.dec", 1, '0);
        step("ill.nop", 0, v(1,1,0,0,1,0,0,0,0,0,3'b000));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS processor.
- Sequences the instruction fetch unit, register file, ALU and data memory over 3-5 cycles per instruction, replacing the single-cycle combinational decoder.
- Drives the IFU's is_jump/is_branch/pc_write, latches instructions via ir_write, and stalls on a memory ready handshake.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting on mem_ready before the fault flag sets (0 disables the timeout).

Ports:
- clk  in  1  system clock, all state changes on posedge
- reset  in  1  synchronous, active-high; forces FETCH on the next posedge
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag (beq compare)
- mem_ready  in  1  memory (instruction or data) access completes this cycle
- ir_write  out  1  latch the fetched instruction
- pc_write  out  1  IFU advances PC this cycle
- is_branch  out  1  IFU selects PC+4+(imm16<<2)
- is_jump  out  1  IFU selects {PC[31:28],addr26,2'b00}
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- reg_dst  out  1  1=rd, 0=rt
- alu_src  out  1  1=sign-extended imm16, 0=rt
- mem_to_reg  out  1  1=memory data, 0=ALU result
- alu_ctl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- state  out  4  current state encoding (debug)
- fault  out  1  sticky memory timeout flag

Behaviour:
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, HALT=11.
- Reset: state=FETCH, fault=0. All outputs are Moore/decoded from state plus opcode/funct/zero and are 0 except as listed below.
- FETCH:
  - mem_read=1.
  - When mem_ready=1: ir_write=1, pc_write=1, move to DECODE. Otherwise hold.
- DECODE: dispatch on opcode.
  - 000000 (R-type) -> EXEC_R
  - 001000 (addi) -> EXEC_I
  - 100011 (lw) and 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - any other opcode -> see Optional Feature
- EXEC_R:
  - reg_dst=1, alu_src=0.
  - alu_ctl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct gives add.
  - Next state WB_ALU.
- EXEC_I: alu_src=1, alu_ctl=add, next state WB_ALU.
- WB_ALU:
  - reg_write=1, mem_to_reg=0.
  - reg_dst=1 for R-type, 0 for addi; alu_src and alu_ctl held from the execute state.
  - Next state FETCH.
- MEM_ADDR: alu_src=1, alu_ctl=add; next state MEM_RD if lw, MEM_WR if sw.
- MEM_RD:
  - mem_read=1, alu_src=1, alu_ctl=add.
  - Hold until mem_ready, then go to WB_MEM.
- MEM_WR:
  - mem_write=1, alu_src=1, alu_ctl=add.
  - Hold until mem_ready, then go to FETCH.
  - mem_write deasserts in the cycle after mem_ready.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
- BRANCH:
  - alu_ctl=sub, alu_src=0.
  - If zero=1: is_branch=1, pc_write=1.
  - Next state FETCH in either case. The PC has already been incremented in FETCH.
- JUMP: is_jump=1, pc_write=1, next state FETCH.
- Latency (with mem_ready=1 on first request):
  - R-type and addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq and j: 3 cycles
- Wait-state timeout:
  - A counter increments each cycle in FETCH, MEM_RD or MEM_WR while mem_ready=0, and clears whenever the state changes.
  - When the counter reaches MEM_TIMEOUT (MEM_TIMEOUT≠0): set fault=1 and go to HALT. The access is abandoned.
- HALT: all enables 0, stays in HALT until reset.
- Reset mid-instruction:
  - Any write enable asserted in that cycle still drives (combinational); next state is FETCH.
  - Pending memory accesses are dropped; fault clears.
- pc_write, reg_write and mem_write are never asserted together. is_branch and is_jump are mutually exclusive.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE moves to HALT, and a 1-bit output port illegal is asserted (sticky, cleared by reset).
- Undefined: an unknown opcode is a NOP, DECODE goes to FETCH (2-cycle instruction), and there is no illegal port.

Test Plan:
- Reset, then opcode=000000 funct=100010, mem_ready=1 -> states 0,1,2,7,0; alu_ctl=110 in EXEC_R; reg_write=1 only in WB_ALU; pc_write only in cycle 1.
- lw (100011) with mem_ready low 3 cycles in MEM_RD -> state 5 held 4 cycles, then WB_MEM with reg_write=1, mem_to_reg=1; total 8 cycles.
- beq with zero=1 -> BRANCH asserts is_branch=1, pc_write=1. Repeat with zero=0 -> both stay 0; 3 cycles each.
- j (000010) -> JUMP asserts is_jump=1, pc_write=1, is_branch=0; back to FETCH next cycle.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> fault=1 and state=11 after 16 cycles; reset clears to FETCH with fault=0.
- opcode=111111 -> with ILLEGAL_TRAP_EN: HALT, illegal=1. Without: DECODE goes to FETCH, no write enables asserted.
